blake2s_sched: RTL and testbench
================================

Name: blake2s_sched

Overview:
- Controller that sequences the BLAKE2s compression datapath from the byte-stream side of the I/O interface.
- Accepts the per-byte block stream (valid, byte index, first/last flags) and the latched kk/nn/ll configuration.
- Tracks block completion and maintains the 64-bit byte counter t and the final flag f.
- Drives h-init, the 10-round x 8-G-step compression schedule and the finalize step, then streams nn hash bytes out.

Parameters:
NB_ROUNDS, 10, compression rounds per block
NB_STEPS, 8, G steps per round (4 column + 4 diagonal), one per cycle
BLOCK_BYTES, 64, bytes per block; t increment for non-last blocks

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
data_v_i  in  1  block byte valid
data_idx_i  in  6  byte index within block, 0..63
block_first_i  in  1  current block is the first of the message
block_last_i  in  1  current block is the last of the message
kk_i  in  6  key length in bytes
nn_i  in  6  digest length in bytes
ll_i  in  64  message length in bytes
ready_v_o  out  1  scheduler can accept block bytes
init_o  out  1  1-cycle pulse: load h from IV xor parameter block
comp_v_o  out  1  compression step active
round_o  out  4  current round, 0..NB_ROUNDS-1
step_o  out  3  current G step, 0..NB_STEPS-1
t_o  out  64  byte counter for the current block
f_o  out  1  final-block flag for the current block
fin_o  out  1  1-cycle pulse: h <= h ^ v_low ^ v_high
hash_v_o  out  1  hash byte valid
hash_idx_o  out  5  hash byte index, 0..nn-1
err_o  out  1  sticky overrun flag (feature only)

Behaviour:
- Clock is clk. Reset is synchronous, active-high, on port reset; reset has priority over every other event.
- Reset values:
  - state=IDLE
  - ready_v_o=1
  - t_o=0, f_o=0, round_o=0, step_o=0, hash_idx_o=0
  - all pulses and valids=0
  - err_o=0
- States:
  - IDLE
  - LOAD
  - INIT
  - COMP
  - FIN
  - OUT
- ready_v_o=1 in IDLE and LOAD only; 0 elsewhere.
- IDLE->LOAD on data_v_i.
- Block completion is data_v_i & data_idx_i==63 while in IDLE or LOAD.
- On block completion:
  - Latch first/last from block_first_i/block_last_i.
  - Update t_o:
    - Last block: t_o <= ll_i + (kk_i!=0 ? 64 : 0), modulo 2^64.
    - Otherwise: t_o <= t_o + 64, wrapping modulo 2^64.
  - Update f_o: f_o <= block_last_i.
  - Next state: INIT if first, else COMP.
- Latency: init_o is high exactly one cycle, in the cycle after the byte-63 edge. Next state is COMP.
- COMP lasts NB_ROUNDS*NB_STEPS = 80 cycles with comp_v_o=1.
  - step_o increments every cycle.
  - step_o wraps 7->0 and increments round_o.
  - Leaving COMP after round 9 step 7: round_o and step_o return to 0.
- FIN: fin_o=1 for one cycle. Then OUT if the latched last flag is set and nn_i!=0; otherwise IDLE.
- OUT:
  - Latch min(nn_i,32) on entry; nn_i>32 is clamped to 32.
  - hash_v_o=1 for that many consecutive cycles, with hash_idx_o=0,1,... .
  - Then IDLE, and t_o is cleared to 0.
- t_o and f_o hold stable from the update edge until the next block completion (or until the clear on leaving OUT).
- data_v_i outside IDLE/LOAD: byte ignored; no state or counter change.
- Reset mid-operation (any state): all outputs return to reset values on the next edge. A partially loaded block is discarded.
- data_v_i with idx!=63: no action beyond IDLE->LOAD.
- Byte-63 edge coincident with reset: reset wins.

Optional Feature:
BLAKE2S_SCHED_ERR_EN
- Defined: err_o is set when data_v_i=1 while ready_v_o=0. err_o is sticky and cleared only by reset.
- Undefined: err_o is tied to 0 and no detection logic is built.

Test Plan:
- reset, then 64 bytes with first=last=1, kk=0, nn=32, ll=3:
  - init_o pulses 1 cycle after idx63.
  - comp_v_o holds 80 cycles; round_o reaches 9, step_o reaches 7.
  - t_o=3, f_o=1.
  - fin_o pulses 1 cycle.
  - hash_v_o holds 32 cycles, hash_idx_o 0..31.
  - Scheduler returns to IDLE with ready_v_o=1.
- ll=100, two blocks (first, then last), nn=16:
  - Block 1: init_o pulses, t_o=64, f_o=0, no hash_v_o; ready_v_o returns 82 cycles after byte 63.
  - Block 2: no init_o, t_o=100, f_o=1, 16 hash bytes.
- kk=16, ll=0, single key block with first=last=1: t_o=64, f_o=1.
- nn=0, single block: fin_o pulses, hash_v_o never asserts, returns to IDLE. Separate run with nn=40: exactly 32 hash bytes.
- data_v_i during COMP cycle 20: schedule unchanged; err_o=1 with the macro defined, err_o=0 without it.
- reset asserted at COMP round 4: next cycle state=IDLE, comp_v_o=0, t_o=0, ready_v_o=1. A fresh block then completes normally.

Source files
------------

// File: rtl/blake2s_sched.sv
// BLAKE2s compression scheduler: counts block bytes, maintains the byte
// counter t and final flag f, then sequences h-init, the round/G-step
// schedule, finalize and hash-byte output.
// Optional overrun detection on err_o: define BLAKE2S_SCHED_ERR_EN.
module blake2s_sched #(
   parameter int NB_ROUNDS   = 10,
   parameter int NB_STEPS    = 8,
   parameter int BLOCK_BYTES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_v_i,
   input  logic [5:0]  data_idx_i,
   input  logic        block_first_i,
   input  logic        block_last_i,
   input  logic [5:0]  kk_i,
   input  logic [5:0]  nn_i,
   input  logic [63:0] ll_i,
   output logic        ready_v_o,
   output logic        init_o,
   output logic        comp_v_o,
   output logic [3:0]  round_o,
   output logic [2:0]  step_o,
   output logic [63:0] t_o,
   output logic        f_o,
   output logic        fin_o,
   output logic        hash_v_o,
   output logic [4:0]  hash_idx_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_INIT, S_COMP, S_FIN, S_OUT
   } state_t;

   state_t      state;
   logic        last_q;     // latched block_last of the block in flight
   logic [5:0]  hash_cnt;   // number of digest bytes to emit, clamped to 32

   logic        in_load;
   logic        blk_done;

   assign in_load  = (state == S_IDLE) || (state == S_LOAD);
   assign blk_done = in_load && data_v_i && (data_idx_i == 6'd63);

   // Main sequencer: all state and outputs registered, pulses default low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         last_q     <= 1'b0;
         hash_cnt   <= 6'd0;
         ready_v_o  <= 1'b1;
         init_o     <= 1'b0;
         comp_v_o   <= 1'b0;
         round_o    <= 4'd0;
         step_o     <= 3'd0;
         t_o        <= 64'd0;
         f_o        <= 1'b0;
         fin_o      <= 1'b0;
         hash_v_o   <= 1'b0;
         hash_idx_o <= 5'd0;
      end else begin
         init_o <= 1'b0;
         fin_o  <= 1'b0;
         case (state)
            S_IDLE, S_LOAD: begin
               if (blk_done) begin
                  last_q    <= block_last_i;
                  f_o       <= block_last_i;
                  ready_v_o <= 1'b0;
                  // Last block carries the whole message length (plus the key block).
                  if (block_last_i)
                     t_o <= ll_i + ((kk_i != 6'd0) ? 64'(BLOCK_BYTES) : 64'd0);
                  else
                     t_o <= t_o + 64'(BLOCK_BYTES);
                  if (block_first_i) begin
                     state  <= S_INIT;
                     init_o <= 1'b1;
                  end else begin
                     state    <= S_COMP;
                     comp_v_o <= 1'b1;
                  end
               end else if (data_v_i && state == S_IDLE) begin
                  state <= S_LOAD;
               end
            end
            S_INIT: begin
               state    <= S_COMP;
               comp_v_o <= 1'b1;
            end
            S_COMP: begin
               if (step_o == 3'(NB_STEPS - 1)) begin
                  step_o <= 3'd0;
                  if (round_o == 4'(NB_ROUNDS - 1)) begin
                     round_o  <= 4'd0;
                     comp_v_o <= 1'b0;
                     fin_o    <= 1'b1;
                     state    <= S_FIN;
                  end else begin
                     round_o <= round_o + 4'd1;
                  end
               end else begin
                  step_o <= step_o + 3'd1;
               end
            end
            S_FIN: begin
               if (last_q && nn_i != 6'd0) begin
                  state      <= S_OUT;
                  hash_v_o   <= 1'b1;
                  hash_idx_o <= 5'd0;
                  hash_cnt   <= (nn_i > 6'd32) ? 6'd32 : nn_i;
               end else begin
                  state     <= S_IDLE;
                  ready_v_o <= 1'b1;
               end
            end
            S_OUT: begin
               if ({1'b0, hash_idx_o} == hash_cnt - 6'd1) begin
                  hash_v_o   <= 1'b0;
                  hash_idx_o <= 5'd0;
                  t_o        <= 64'd0;
                  state      <= S_IDLE;
                  ready_v_o  <= 1'b1;
               end else begin
                  hash_idx_o <= hash_idx_o + 5'd1;
               end
            end
            default: begin
               state     <= S_IDLE;
               ready_v_o <= 1'b1;
               comp_v_o  <= 1'b0;
               hash_v_o  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BLAKE2S_SCHED_ERR_EN
   // Sticky overrun: a byte offered while the scheduler is busy.
   always_ff @(posedge clk) begin
      if (reset)
         err_o <= 1'b0;
      else if (data_v_i && !ready_v_o)
         err_o <= 1'b1;
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_blake2s_sched.sv
// Self-checking bench for blake2s_sched: table vectors, corner sequences
// and randomized messages against a per-cycle expected schedule.
module tb_blake2s_sched;

   logic        clk;
   logic        reset;
   logic        data_v_i;
   logic [5:0]  data_idx_i;
   logic        block_first_i;
   logic        block_last_i;
   logic [5:0]  kk_i;
   logic [5:0]  nn_i;
   logic [63:0] ll_i;
   logic        ready_v_o;
   logic        init_o;
   logic        comp_v_o;
   logic [3:0]  round_o;
   logic [2:0]  step_o;
   logic [63:0] t_o;
   logic        f_o;
   logic        fin_o;
   logic        hash_v_o;
   logic [4:0]  hash_idx_o;
   logic        err_o;

   blake2s_sched dut (
      .clk(clk), .reset(reset), .data_v_i(data_v_i), .data_idx_i(data_idx_i),
      .block_first_i(block_first_i), .block_last_i(block_last_i),
      .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i), .ready_v_o(ready_v_o),
      .init_o(init_o), .comp_v_o(comp_v_o), .round_o(round_o), .step_o(step_o),
      .t_o(t_o), .f_o(f_o), .fin_o(fin_o), .hash_v_o(hash_v_o),
      .hash_idx_o(hash_idx_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int tot_cnt  = 0;
   logic        err_exp;   // expected sticky error state
   logic [63:0] t_m;       // model byte counter

   typedef struct {
      bit          first;
      bit          last;
      logic [5:0]  kk;
      logic [5:0]  nn;
      logic [63:0] ll;
      logic [63:0] exp_t;
      bit          exp_f;
      int          nh;      // expected number of hash bytes
      int          poke;    // cycle after byte 63 to inject a stray byte (0 = none)
   } vec_t;

   vec_t vt[7];

   function automatic logic [127:0] bun(logic rdy, logic ini, logic cv, logic [3:0] rnd,
                                        logic [2:0] stp, logic fn, logic hv, logic [4:0] hi,
                                        logic er, logic f, logic [63:0] t);
      return {45'd0, rdy, ini, cv, rnd, stp, fn, hv, hi, er, f, t};
   endfunction

   function automatic logic [127:0] dut_bun();
      return bun(ready_v_o, init_o, comp_v_o, round_o, step_o, fin_o, hash_v_o,
                 hash_idx_o, err_o, f_o, t_o);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Offer bytes 0..63 of one block, with occasional idle gaps.
   task automatic drive_bytes(input bit first, input bit last, input logic [5:0] kk,
                              input logic [5:0] nn, input logic [63:0] ll, input bit rst_last);
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            data_v_i = 1'b0;
         end
         @(negedge clk);
         data_v_i      = 1'b1;
         data_idx_i    = 6'(i);
         block_first_i = first;
         block_last_i  = last;
         kk_i = kk; nn_i = nn; ll_i = ll;
         if (rst_last && i == 63) reset = 1'b1;
      end
   endtask

   // One block plus the full expected schedule after its byte-63 edge.
   task automatic run_block(input string nm, input bit first, input bit last,
                            input logic [5:0] kk, input logic [5:0] nn, input logic [63:0] ll,
                            input logic [63:0] exp_t, input bit exp_f, input int nh,
                            input int poke);
      int off;
      int total;
      logic [127:0] e;
      drive_bytes(first, last, kk, nn, ll, 1'b0);
      off   = first ? 1 : 0;
      total = off + 82 + nh;
      for (int c = 1; c <= total; c++) begin
         @(negedge clk);
         if (c == 1 || c == poke + 1) data_v_i = 1'b0;
         if (first && c == 1)
            e = bun(0, 1, 0, 0, 0, 0, 0, 0, err_exp, exp_f, exp_t);
         else if (c <= off + 80)
            e = bun(0, 0, 1, 4'((c - off - 1) / 8), 3'((c - off - 1) % 8), 0, 0, 0,
                    err_exp, exp_f, exp_t);
         else if (c == off + 81)
            e = bun(0, 0, 0, 0, 0, 1, 0, 0, err_exp, exp_f, exp_t);
         else if (c < total)
            e = bun(0, 0, 0, 0, 0, 0, 1, 5'(c - off - 82), err_exp, exp_f, exp_t);
         else
            e = bun(1, 0, 0, 0, 0, 0, 0, 0, err_exp, exp_f, (nh > 0) ? 64'd0 : exp_t);
         chk($sformatf("%s c%0d", nm, c), dut_bun(), e);
         if (poke != 0 && c == poke) begin
            data_v_i = 1'b1; data_idx_i = 6'd63; block_first_i = 1'b1;
`ifdef BLAKE2S_SCHED_ERR_EN
            err_exp = 1'b1;
`endif
         end
      end
   endtask

   initial begin
      logic [127:0] rst_b;
      reset = 1'b1; data_v_i = 1'b0; data_idx_i = 6'd0; block_first_i = 1'b0;
      block_last_i = 1'b0; kk_i = 6'd0; nn_i = 6'd0; ll_i = 64'd0;
      err_exp = 1'b0; t_m = 64'd0;
      rst_b = bun(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0);
      repeat (2) @(negedge clk);
      chk("reset", dut_bun(), rst_b);
      reset = 1'b0;

      vt[0] = '{1, 1, 6'd0,  6'd32, 64'd3,   64'd3,   1, 32, 22};
      vt[1] = '{1, 0, 6'd0,  6'd16, 64'd100, 64'd64,  0, 0,  0};
      vt[2] = '{0, 1, 6'd0,  6'd16, 64'd100, 64'd100, 1, 16, 0};
      vt[3] = '{1, 1, 6'd16, 6'd32, 64'd0,   64'd64,  1, 32, 0};
      vt[4] = '{1, 1, 6'd0,  6'd0,  64'd5,   64'd5,   1, 0,  0};
      vt[5] = '{1, 1, 6'd0,  6'd40, 64'd7,   64'd7,   1, 32, 0};
      vt[6] = '{1, 1, 6'd1,  6'd8,  64'hFFFF_FFFF_FFFF_FFF0, 64'h30, 1, 8, 0};
      for (int v = 0; v < 7; v++)
         run_block($sformatf("vec%0d", v), vt[v].first, vt[v].last, vt[v].kk, vt[v].nn,
                   vt[v].ll, vt[v].exp_t, vt[v].exp_f, vt[v].nh, vt[v].poke);

      // Byte-63 edge coincident with reset: reset wins, no INIT follows.
      drive_bytes(1, 1, 6'd0, 6'd4, 64'd9, 1'b1);
      @(negedge clk);
      data_v_i = 1'b0; reset = 1'b0;
      chk("rst_on_63", dut_bun(), rst_b);
      @(negedge clk);
      chk("rst_on_63_idle", dut_bun(), rst_b);
      err_exp = 1'b0;

      // Reset in the middle of round 4.
      drive_bytes(1, 1, 6'd0, 6'd32, 64'd9, 1'b0);
      @(negedge clk);
      data_v_i = 1'b0;
      repeat (33) @(negedge clk);
      chk("mid_pre", dut_bun(), bun(0, 0, 1, 4'd4, 3'd0, 0, 0, 0, 0, 1, 64'd9));
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst", dut_bun(), rst_b);
      reset = 1'b0;
      t_m = 64'd0;
      run_block("after_rst", 1, 1, 6'd0, 6'd2, 64'd50, 64'd50, 1, 2, 0);

      // Randomized messages against the model counter.
      for (int m = 0; m < 6; m++) begin
         int nb;
         int nh;
         logic [5:0]  kk;
         logic [5:0]  nn;
         logic [63:0] ll;
         nb = $urandom_range(1, 3);
         kk = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 32)) : 6'd0;
         nn = 6'($urandom_range(0, 40));
         ll = {$urandom, $urandom};
         for (int b = 0; b < nb; b++) begin
            bit first;
            bit last;
            first = (b == 0);
            last  = (b == nb - 1);
            if (last) t_m = ll + ((kk != 0) ? 64'd64 : 64'd0);
            else      t_m = t_m + 64'd64;
            nh = (last && nn != 0) ? ((nn > 32) ? 32 : int'(nn)) : 0;
            run_block($sformatf("rnd%0d_b%0d", m, b), first, last, kk, nn, ll,
                      t_m, last, nh, 0);
            if (nh > 0) t_m = 64'd0;
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
